// File: rtl/inst_fetch_buffer.sv
// Instruction fetch queue: 1-4 contiguous ICache slots in, 2 oldest entries out to dual-issue decode.
// Optional macro IFB_BYPASS_EN: 0-cycle fetch-to-decode bypass when the buffer is empty.
module inst_fetch_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid_1,
    input  logic             in_valid_2,
    input  logic             in_valid_3,
    input  logic             in_valid_4,
    input  logic [31:0]      in_inst_1,
    input  logic [31:0]      in_inst_2,
    input  logic [31:0]      in_inst_3,
    input  logic [31:0]      in_inst_4,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    output logic             out_valid_1,
    output logic             out_valid_2,
    output logic [31:0]      out_inst_1,
    output logic [31:0]      out_inst_2,
    output logic [31:0]      out_pc_1,
    output logic [31:0]      out_pc_2,
    input  logic [1:0]       out_take,
    output logic [PTR_W:0]   count
);

    localparam int SLOTS = 4;
    localparam logic [PTR_W:0] CNT_LIM = (PTR_W+1)'(DEPTH - SLOTS);

    logic [31:0]             inst_mem [DEPTH];
    logic [31:0]             pc_mem   [DEPTH];
    logic [PTR_W-1:0]        head, tail, head_p1;
    logic [SLOTS-1:0]        slot_vld;
    logic [SLOTS-1:0][31:0]  slot_inst, slot_pc;
    logic [SLOTS-1:0][1:0]   wr_sel;
    logic [2:0]              n_in, n_out, n_wr, n_deq, skip, take_c;
    logic                    byp;

    assign slot_vld  = {in_valid_4, in_valid_3, in_valid_2, in_valid_1};
    assign slot_inst = {in_inst_4, in_inst_3, in_inst_2, in_inst_1};

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot_pc
        assign slot_pc[g] = in_pc + 32'(4 * g);
    end

    assign in_ready = (count <= CNT_LIM);
    assign take_c   = (out_take == 2'd3) ? 3'd2 : {1'b0, out_take};
    assign head_p1  = head + PTR_W'(1);

`ifdef IFB_BYPASS_EN
    assign byp = (count == '0) && !flush;
`else
    assign byp = 1'b0;
`endif

    // Only the leading run of valid slots counts; a hole ends the group.
    always_comb begin
        n_in = 3'd0;
        if (in_ready && !flush) begin
            if (slot_vld[0])      n_in = 3'd1;
            if (&slot_vld[1:0])   n_in = 3'd2;
            if (&slot_vld[2:0])   n_in = 3'd3;
            if (&slot_vld)        n_in = 3'd4;
        end
    end

    always_comb begin
        n_out = 3'd0;
        if (flush)
            n_out = 3'd0;
        else if (byp)
            n_out = (take_c < n_in) ? take_c : n_in;
        else
            n_out = ({2'b0, take_c} > count) ? count[2:0] : take_c;
    end

    // Bypassed slots go straight to decode and are never written.
    assign skip  = byp ? n_out : 3'd0;
    assign n_wr  = n_in - skip;
    assign n_deq = byp ? 3'd0 : n_out;

    always_comb begin
        for (int k = 0; k < SLOTS; k++)
            wr_sel[k] = 2'(skip + 3'(k));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_deq);
            tail  <= tail + PTR_W'(n_wr);
            count <= count + (PTR_W+1)'(n_wr) - (PTR_W+1)'(n_deq);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < SLOTS; k++) begin
            if (3'(k) < n_wr) begin
                inst_mem[tail + PTR_W'(k)] <= slot_inst[wr_sel[k]];
                pc_mem[tail + PTR_W'(k)]   <= slot_pc[wr_sel[k]];
            end
        end
    end

    always_comb begin
        out_valid_1 = 1'b0;
        out_valid_2 = 1'b0;
        out_inst_1  = '0;
        out_inst_2  = '0;
        out_pc_1    = '0;
        out_pc_2    = '0;
        if (byp) begin
            out_valid_1 = slot_vld[0] && in_ready;
            out_valid_2 = slot_vld[0] && slot_vld[1] && in_ready;
            if (out_valid_1) begin
                out_inst_1 = slot_inst[0];
                out_pc_1   = slot_pc[0];
            end
            if (out_valid_2) begin
                out_inst_2 = slot_inst[1];
                out_pc_2   = slot_pc[1];
            end
        end else begin
            out_valid_1 = (count != '0);
            out_valid_2 = (count >= (PTR_W+1)'(2));
            if (out_valid_1) begin
                out_inst_1 = inst_mem[head];
                out_pc_1   = pc_mem[head];
            end
            if (out_valid_2) begin
                out_inst_2 = inst_mem[head_p1];
                out_pc_2   = pc_mem[head_p1];
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: vector table plus a queue-based reference of buffer contents.
module tb_inst_fetch_buffer;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic             clk = 1'b0;
    logic             resetn, flush;
    logic             in_valid_1, in_valid_2, in_valid_3, in_valid_4;
    logic [31:0]      in_inst_1, in_inst_2, in_inst_3, in_inst_4, in_pc;
    logic             in_ready;
    logic             out_valid_1, out_valid_2;
    logic [31:0]      out_inst_1, out_inst_2, out_pc_1, out_pc_2;
    logic [1:0]       out_take;
    logic [PTR_W:0]   count;

    inst_fetch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
        .in_valid_3(in_valid_3), .in_valid_4(in_valid_4),
        .in_inst_1(in_inst_1), .in_inst_2(in_inst_2),
        .in_inst_3(in_inst_3), .in_inst_4(in_inst_4),
        .in_pc(in_pc), .in_ready(in_ready),
        .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
        .out_inst_1(out_inst_1), .out_inst_2(out_inst_2),
        .out_pc_1(out_pc_1), .out_pc_2(out_pc_2),
        .out_take(out_take), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic [3:0]  v;      // bit0 = slot 1
        logic [31:0] pc;
        logic [1:0]  take;
        logic        fl;
        int          exp_cnt;
    } vec_t;

    ent_t        sbq[$];
    vec_t        tbl[26];
    int          checks = 0;
    int          errors = 0;
    int          grp = 0;
    logic [31:0] s_inst[4];
    logic [31:0] s_pc[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lead(input logic [3:0] v);
        if (!v[0]) return 0;
        if (!v[1]) return 1;
        if (!v[2]) return 2;
        if (!v[3]) return 3;
        return 4;
    endfunction

    // Drive one cycle, compare outputs against the reference queue mid-cycle, then advance it.
    task automatic step(input logic [3:0] v, input logic [31:0] pc, input logic [1:0] take,
                        input logic fl);
        int          sz, nin, nout, tk, first;
        logic        rdy, byp, e1v, e2v;
        logic [31:0] e1i, e1p, e2i, e2p;
        grp++;
        for (int k = 0; k < 4; k++) begin
            s_pc[k]   = pc + 32'(4 * k);
            s_inst[k] = 32'hA000_0000 + 32'(grp * 16 + k);
        end
        {in_valid_4, in_valid_3, in_valid_2, in_valid_1} = v;
        in_inst_1 = s_inst[0];
        in_inst_2 = s_inst[1];
        in_inst_3 = s_inst[2];
        in_inst_4 = s_inst[3];
        in_pc     = pc;
        out_take  = take;
        flush     = fl;
        @(negedge clk);
        sz  = sbq.size();
        rdy = (DEPTH - sz) >= 4;
        tk  = (take == 2'd3) ? 2 : int'(take);
        byp = 1'b0;
`ifdef IFB_BYPASS_EN
        byp = (sz == 0) && !fl;
`endif
        e1v = 1'b0; e2v = 1'b0;
        e1i = '0; e1p = '0; e2i = '0; e2p = '0;
        if (byp) begin
            e1v = v[0] && rdy;
            e2v = v[0] && v[1] && rdy;
            if (e1v) begin e1i = s_inst[0]; e1p = s_pc[0]; end
            if (e2v) begin e2i = s_inst[1]; e2p = s_pc[1]; end
        end else begin
            if (sz >= 1) begin e1v = 1'b1; e1i = sbq[0].inst; e1p = sbq[0].pc; end
            if (sz >= 2) begin e2v = 1'b1; e2i = sbq[1].inst; e2p = sbq[1].pc; end
        end
        chk("in_ready", in_ready, rdy);
        chk("count", count, sz);
        chk("out_valid_1", out_valid_1, e1v);
        chk("out_valid_2", out_valid_2, e2v);
        chk("out_inst_1", out_inst_1, e1i);
        chk("out_pc_1", out_pc_1, e1p);
        chk("out_inst_2", out_inst_2, e2i);
        chk("out_pc_2", out_pc_2, e2p);
        nin = (rdy && !fl) ? lead(v) : 0;
        @(posedge clk);
        if (fl) begin
            sbq.delete();
        end else begin
            first = 0;
            if (byp) begin
                first = (tk < nin) ? tk : nin;
            end else begin
                nout = (tk < sz) ? tk : sz;
                repeat (nout) void'(sbq.pop_front());
            end
            for (int k = first; k < nin; k++)
                sbq.push_back('{inst: s_inst[k], pc: s_pc[k]});
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b1111, 32'hBFC0_0000, 2'd0, 1'b0, 4};
        tbl[1]  = '{4'b0000, 32'h0,         2'd2, 1'b0, 2};
        tbl[2]  = '{4'b0000, 32'h0,         2'd2, 1'b0, 0};
        tbl[3]  = '{4'b0000, 32'h0,         2'd2, 1'b0, 0};
        tbl[4]  = '{4'b1111, 32'h0000_1000, 2'd0, 1'b0, 4};
        tbl[5]  = '{4'b1111, 32'h0000_1010, 2'd0, 1'b0, 8};
        tbl[6]  = '{4'b1111, 32'h0000_1020, 2'd0, 1'b0, 12};
        tbl[7]  = '{4'b0001, 32'h0000_1030, 2'd0, 1'b0, 13};
        tbl[8]  = '{4'b1111, 32'h0000_2000, 2'd0, 1'b0, 13};
        tbl[9]  = '{4'b0000, 32'h0,         2'd1, 1'b0, 12};
        tbl[10] = '{4'b1011, 32'h0000_3000, 2'd0, 1'b0, 14};
        tbl[11] = '{4'b1111, 32'h0000_3100, 2'd2, 1'b1, 0};
        tbl[12] = '{4'b1111, 32'h0000_4000, 2'd0, 1'b0, 4};
        tbl[13] = '{4'b1111, 32'h0000_4010, 2'd2, 1'b0, 6};
        tbl[14] = '{4'b1111, 32'h0000_4020, 2'd2, 1'b0, 8};
        tbl[15] = '{4'b0011, 32'h0000_4030, 2'd2, 1'b0, 8};
        tbl[16] = '{4'b0000, 32'h0,         2'd2, 1'b0, 6};
        tbl[17] = '{4'b0000, 32'h0,         2'd2, 1'b0, 4};
        tbl[18] = '{4'b0000, 32'h0,         2'd2, 1'b0, 2};
        tbl[19] = '{4'b0000, 32'h0,         2'd2, 1'b0, 0};
        tbl[20] = '{4'b1111, 32'hFFFF_FFF8, 2'd0, 1'b0, 4};
        tbl[21] = '{4'b1111, 32'h0000_5000, 2'd1, 1'b0, 7};
        tbl[22] = '{4'b0000, 32'h0,         2'd2, 1'b0, 5};
        tbl[23] = '{4'b0000, 32'h0,         2'd3, 1'b0, 3};
        tbl[24] = '{4'b0000, 32'h0,         2'd2, 1'b0, 1};
        tbl[25] = '{4'b0000, 32'h0,         2'd2, 1'b0, 0};

        resetn = 1'b0; flush = 1'b0; out_take = 2'd0; in_pc = '0;
        {in_valid_4, in_valid_3, in_valid_2, in_valid_1} = 4'b0;
        in_inst_1 = '0; in_inst_2 = '0; in_inst_3 = '0; in_inst_4 = '0;
        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_out_valid_1", out_valid_1, 1'b0);
        chk("rst_out_valid_2", out_valid_2, 1'b0);
        chk("rst_out_inst_1", out_inst_1, 32'h0);
        chk("rst_out_pc_2", out_pc_2, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].v, tbl[i].pc, tbl[i].take, tbl[i].fl);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
        end

        // Empty buffer, 3-slot write with take 2 in the same cycle.
        step(4'b0111, 32'h8000_0000, 2'd2, 1'b0);
`ifdef IFB_BYPASS_EN
        chk("empty_wr3_count", count, 1);
        chk("empty_wr3_head", out_inst_1, s_inst[2]);
        chk("empty_wr3_pc", out_pc_1, 32'h8000_0008);
`else
        chk("empty_wr3_count", count, 3);
        chk("empty_wr3_head", out_inst_1, s_inst[0]);
        chk("empty_wr3_pc", out_pc_1, 32'h8000_0000);
`endif
        step(4'b0000, 32'h0, 2'd2, 1'b0);
        step(4'b0000, 32'h0, 2'd2, 1'b0);
        chk("drain_count", count, 0);

        // Flush while holding entries, then refill from index 0.
        step(4'b1111, 32'h0000_6000, 2'd0, 1'b0);
        step(4'b0000, 32'h0, 2'd0, 1'b1);
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid_1, 1'b0);
        step(4'b0011, 32'h0000_7000, 2'd0, 1'b0);
        step(4'b0000, 32'h0, 2'd1, 1'b0);
        step(4'b0000, 32'h0, 2'd1, 1'b0);
        chk("final_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Instruction fetch queue between the ICache and the dual-issue decode stage.
- Each cycle it accepts 1-4 contiguous instructions from the ICache read ports (slots 1-4) together with the PC of slot 1.
- Each cycle it presents the two oldest instructions, with their PCs, to decode.
- Decode tells it how many it consumed (0/1/2). This decouples the ICache burst width from the issue width, and flushes on redirect.

Parameters:
- DEPTH, 16, number of entries; must be a power of 2 and >= 8.
- PTR_W, 4, log2(DEPTH); entry pointer width.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- flush  input  1  discard all entries (branch/exception redirect)
- in_valid_1..in_valid_4  input  1 each  slot valid; driven by ICache i_ready_1..4
- in_inst_1..in_inst_4  input  32 each  instruction words; driven by ICache i_rdata_1..4
- in_pc  input  32  PC of slot 1; slot k has PC in_pc+4*(k-1)
- in_ready  output  1  buffer can accept a full 4-slot group this cycle
- out_valid_1, out_valid_2  output  1 each  oldest / second-oldest entry valid
- out_inst_1, out_inst_2  output  32 each  instructions
- out_pc_1, out_pc_2  output  32 each  PCs
- out_take  input  2  entries consumed this cycle: 0, 1 or 2; value 3 is treated as 2
- count  output  PTR_W+1  current occupancy

Behaviour:
- Storage: DEPTH entries of {inst[31:0], pc[31:0]}; head pointer, tail pointer and count registers, all PTR_W/PTR_W/PTR_W+1 bits. Pointers wrap modulo DEPTH naturally.
- Reset (resetn=0, async): head=tail=count=0. Outputs: in_ready=1, out_valid_*=0, out_inst_*=0, out_pc_*=0, count=0. Entry contents are don't-care.
- in_ready = (DEPTH - count) >= 4, combinational from registered count. It does not depend on out_take in the same cycle (conservative, no combinational path from decode).
- n_in = number of leading asserted in_valid bits (1, 1-2, 1-3, 1-4).
  - Slots after the first deasserted valid are ignored.
  - n_in = 0 when in_ready=0 or flush=1.
- Enqueue at the clk edge: entry tail+k-1 gets in_inst_k and in_pc+4*(k-1) for k=1..n_in; tail += n_in.
- Read side: outputs are combinational from registered state.
  - out_valid_1 = count>=1; out_valid_2 = count>=2.
  - out_inst/pc_1 = entry[head]; out_inst/pc_2 = entry[head+1], wrapping.
  - An invalid slot drives inst and pc to 0.
- n_out = min(out_take clamped to 2, count); 0 when flush=1. head += n_out.
- count_next = count + n_in - n_out. Simultaneous enqueue and dequeue is legal in the same cycle. count never exceeds DEPTH; in_ready guarantees this.
- Latency: an enqueued instruction is visible on out_* the cycle after it is written (1 cycle), unless bypass is enabled.
- flush=1: at the next edge head=tail=count=0. Enqueue and dequeue in the flush cycle are dropped. flush overrides all other inputs.
- Empty: out_valid_*=0; out_take is ignored.
- Full or count > DEPTH-4: in_ready=0, and inputs are dropped. The ICache must hold, using its stall, while in_ready=0.
- Wrap-around: a 4-slot write or 2-slot read crossing index DEPTH-1 -> 0 is split correctly across the boundary.
- PC arithmetic is 32-bit modulo 2^32.

Optional Feature:
- Macro IFB_BYPASS_EN.
- When defined and count==0 and flush==0:
  - out_valid_1/2 and out_inst/pc_1/2 are driven combinationally from in slots 1/2, gated by in_valid and in_ready.
  - The n_out bypassed instructions (n_out = min(out_take, n_in)) are not written.
  - Only the remaining n_in-n_out are enqueued, starting at slot n_out+1. count_next = n_in - n_out.
  - Gives 0-cycle fetch-to-decode latency when empty.
- When undefined: outputs depend only on registered state (1-cycle latency); no combinational path from in_* to out_*.

Test Plan:
- Reset, then 4-slot write: insts A0..A3, in_pc=0xBFC00000, out_take=0 -> next cycle count=4; out_1=A0@0xBFC00000, out_2=A1@0xBFC00004.
- out_take=2 for two cycles after that write, no input -> out_1 shows A2@0xBFC00008, then count=0 and out_valid_1=0.
- Fill to count=13 with out_take=0 -> in_ready=0. A further 4-slot write is dropped and count stays 13. Take 1 -> count=12, in_ready=1.
- Wrap: head=tail=14. Write 4 (entries 14, 15, 0, 1) while taking 2 each cycle -> sequence and PCs are in order across the boundary, count matches.
- Non-contiguous valid 1,1,0,1 -> only 2 entries enqueued. flush asserted together with a 4-slot write and out_take=2 -> count=0 next cycle, nothing enqueued.
- IFB_BYPASS_EN: empty buffer, 3-slot write, out_take=2 in the same cycle -> out_1/out_2 equal slots 1/2 that cycle; next cycle count=1 holding slot 3.
